// File: rtl/tdc_readout_if.sv
// Result bus of the TDC readout stage.
// Valid/ready handshake plus the accumulated measurement.
interface tdc_readout_if #(
  parameter int LOG2_N = 4
);
  logic              out_valid;
  logic              out_ready;
  logic [3+LOG2_N:0] sum;
  logic [3:0]        min_cnt;
  logic [3:0]        max_cnt;
  logic [7:0]        bubble_cnt;
  logic [7:0]        miss_cnt;

  modport master (
    output out_valid,
    output sum,
    output min_cnt,
    output max_cnt,
    output bubble_cnt,
    output miss_cnt,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  sum,
    input  min_cnt,
    input  max_cnt,
    input  bubble_cnt,
    input  miss_cnt,
    output out_ready
  );
endinterface

// File: rtl/tdc_readout.sv
// TDC readout: sync, bubble-correct, count and
// accumulate 2^LOG2_N hits into sum/min/max.
module tdc_readout #(
  parameter int LOG2_N        = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] term,
  input  logic       hit,
  input  logic       arm,
  output logic       busy,
  tdc_readout_if.master res
);

  localparam int SW = 4 + LOG2_N;
  localparam logic [8:0] LAST = 9'((1 << LOG2_N) - 1);
  localparam logic [3:0] SLOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETTLE,
    S_CAPT,
    S_DONE
  } state_t;

  logic [7:0] term_s1_q, term_s2_q;
  logic       hit_s1_q, hit_s2_q, hit_s3_q;
  logic       hit_edge;

  state_t     state_q, state_d;
  logic [3:0] settle_q, settle_d;
  logic [8:0] idx_q, idx_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [3:0] min_q, min_d;
  logic [3:0] max_q, max_d;
  logic [7:0] bub_q, bub_d;
  logic [7:0] miss_q, miss_d;
  logic       busy_q, busy_d;
  logic       valid_q, valid_d;

  logic [9:0] ext;
  logic [7:0] corr;
  logic       bubble;
  logic [3:0] cnt;
  logic       run;
  logic       clr;
  logic       miss_inc;

  // Two-flop synchronizers plus edge register for hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      term_s1_q <= '0;
      term_s2_q <= '0;
      hit_s1_q  <= 1'b0;
      hit_s2_q  <= 1'b0;
      hit_s3_q  <= 1'b0;
    end else begin
      term_s1_q <= term;
      term_s2_q <= term_s1_q;
      hit_s1_q  <= hit;
      hit_s2_q  <= hit_s1_q;
      hit_s3_q  <= hit_s2_q;
    end
  end

  assign hit_edge = hit_s2_q & ~hit_s3_q;

  // Majority bubble correction and leading-ones count.
  always_comb begin
    ext  = {1'b0, term_s2_q, 1'b1};
    corr = '0;
    for (int k = 0; k < 8; k++) begin
      corr[k] = (ext[k] & ext[k+1]) |
                (ext[k] & ext[k+2]) |
                (ext[k+1] & ext[k+2]);
    end
    bubble = (corr != term_s2_q);
    cnt = '0;
    run = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (run && corr[k]) begin
        cnt = cnt + 4'd1;
      end else begin
        run = 1'b0;
      end
    end
  end

  // Next state and accumulator updates.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    min_d    = min_q;
    max_d    = max_q;
    bub_d    = bub_q;
    miss_d   = miss_q;
    clr      = 1'b0;
    miss_inc = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (arm) begin
          clr     = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (arm) begin
          clr = 1'b1;
        end else if (hit_edge) begin
          state_d  = S_SETTLE;
          settle_d = SLOAD;
        end
      end
      S_SETTLE: begin
        if (arm) begin
          clr     = 1'b1;
          state_d = S_WAIT;
        end else begin
          miss_inc = hit_edge;
          if (settle_q == 4'd0) begin
            state_d = S_CAPT;
          end else begin
            settle_d = settle_q - 4'd1;
          end
        end
      end
      S_CAPT: begin
        if (arm) begin
          clr     = 1'b1;
          state_d = S_WAIT;
        end else begin
          miss_inc = hit_edge;
          sum_d = sum_q + SW'(cnt);
          if (cnt < min_q) min_d = cnt;
          if (cnt > max_q) max_d = cnt;
          if (bubble && bub_q != 8'hFF) begin
            bub_d = bub_q + 8'd1;
          end
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 9'd1;
            state_d = S_WAIT;
          end
        end
      end
      S_DONE: begin
        miss_inc = hit_edge;
        if (res.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (miss_inc && miss_q != 8'hFF) begin
      miss_d = miss_q + 8'd1;
    end
    if (clr) begin
      sum_d  = '0;
      bub_d  = '0;
      miss_d = '0;
      idx_d  = '0;
      min_d  = 4'd8;
      max_d  = 4'd0;
    end
    busy_d  = (state_d == S_WAIT) ||
              (state_d == S_SETTLE) ||
              (state_d == S_CAPT);
    valid_d = (state_d == S_DONE);
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      min_q    <= 4'd8;
      max_q    <= 4'd0;
      bub_q    <= '0;
      miss_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      min_q    <= min_d;
      max_q    <= max_d;
      bub_q    <= bub_d;
      miss_q   <= miss_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign busy           = busy_q;
  assign res.out_valid  = valid_q;
  assign res.sum        = sum_q;
  assign res.min_cnt    = min_q;
  assign res.max_cnt    = max_q;
  assign res.bubble_cnt = bub_q;
  assign res.miss_cnt   = miss_q;

endmodule

// File: tb/tb_tdc_readout.sv
// Directed bench for tdc_readout.
// LOG2_N=2 (4 hits), SETTLE_CYCLES=2.
module tb_tdc_readout;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] term = 8'h00;
  logic       hit = 1'b0;
  logic       arm = 1'b0;
  logic       busy;
  int         checks = 0;
  int         failures = 0;

  tdc_readout_if #(.LOG2_N(2)) rif ();

  tdc_readout #(
    .LOG2_N(2),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .term (term),
    .hit  (hit),
    .arm  (arm),
    .busy (busy),
    .res  (rif.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_hit(input logic [7:0] t);
    term = t;
    cyc(3);
    hit = 1'b1;
    cyc(1);
    hit = 1'b0;
    cyc(6);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
  endtask

  task automatic handshake();
    rif.out_ready = 1'b1;
    cyc(1);
    rif.out_ready = 1'b0;
  endtask

  initial begin
    rif.out_ready = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    check("rst_valid", 32'(rif.out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sum", 32'(rif.sum), 0);
    check("rst_min", 32'(rif.min_cnt), 8);
    check("rst_max", 32'(rif.max_cnt), 0);
    check("rst_bub", 32'(rif.bubble_cnt), 0);
    check("rst_miss", 32'(rif.miss_cnt), 0);

    do_hit(8'h0F);
    check("idle_miss", 32'(rif.miss_cnt), 0);
    check("idle_busy", 32'(busy), 0);

    do_arm();
    check("arm_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) do_hit(8'h0F);
    check("m1_valid", 32'(rif.out_valid), 1);
    check("m1_busy", 32'(busy), 0);
    check("m1_sum", 32'(rif.sum), 16);
    check("m1_min", 32'(rif.min_cnt), 4);
    check("m1_max", 32'(rif.max_cnt), 4);
    check("m1_bub", 32'(rif.bubble_cnt), 0);
    cyc(5);
    check("m1_hold", 32'(rif.out_valid), 1);
    do_arm();
    check("done_arm_valid", 32'(rif.out_valid), 1);
    check("done_arm_sum", 32'(rif.sum), 16);
    handshake();
    check("m1_hs_valid", 32'(rif.out_valid), 0);
    check("m1_hs_busy", 32'(busy), 0);
    check("m1_keep_sum", 32'(rif.sum), 16);

    // 0x17 corrects to 0x0F (4), 0x0B to 0x07 (3).
    do_arm();
    check("m2_clr_sum", 32'(rif.sum), 0);
    do_hit(8'b0001_0111);
    check("bub1_sum", 32'(rif.sum), 4);
    check("bub1_cnt", 32'(rif.bubble_cnt), 1);
    do_hit(8'b0000_1011);
    check("bub2_sum", 32'(rif.sum), 7);
    check("bub2_cnt", 32'(rif.bubble_cnt), 2);
    do_hit(8'h00);
    do_hit(8'hFF);
    check("m2_valid", 32'(rif.out_valid), 1);
    check("m2_sum", 32'(rif.sum), 15);
    check("m2_min", 32'(rif.min_cnt), 0);
    check("m2_max", 32'(rif.max_cnt), 8);
    check("m2_bub", 32'(rif.bubble_cnt), 2);
    handshake();

    term = 8'h0F;
    do_arm();
    cyc(3);
    for (int i = 0; i < 8; i++) begin
      hit = 1'b1;
      cyc(1);
      hit = 1'b0;
      cyc(2);
    end
    cyc(6);
    check("sp_valid", 32'(rif.out_valid), 1);
    check("sp_sum", 32'(rif.sum), 16);
    check("sp_miss", 32'(rif.miss_cnt), 4);
    handshake();

    do_arm();
    do_hit(8'hFF);
    do_hit(8'hFF);
    check("rearm_part", 32'(rif.sum), 16);
    do_arm();
    check("rearm_sum", 32'(rif.sum), 0);
    check("rearm_min", 32'(rif.min_cnt), 8);
    check("rearm_max", 32'(rif.max_cnt), 0);
    check("rearm_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) do_hit(8'h03);
    check("rearm_3valid", 32'(rif.out_valid), 0);
    do_hit(8'h03);
    check("rearm_valid", 32'(rif.out_valid), 1);
    check("rearm_fsum", 32'(rif.sum), 8);
    check("rearm_fmin", 32'(rif.min_cnt), 2);
    handshake();

    do_arm();
    for (int i = 0; i < 4; i++) do_hit(8'h01);
    for (int i = 0; i < 3; i++) do_hit(8'hFF);
    check("dn_valid", 32'(rif.out_valid), 1);
    check("dn_sum", 32'(rif.sum), 4);
    check("dn_max", 32'(rif.max_cnt), 1);
    check("dn_miss", 32'(rif.miss_cnt), 3);
    handshake();
    check("dn_hs_valid", 32'(rif.out_valid), 0);

    do_arm();
    do_hit(8'hFF);
    check("rs_pre_sum", 32'(rif.sum), 8);
    hit = 1'b1;
    cyc(1);
    hit = 1'b0;
    cyc(2);
    check("rs_settle_busy", 32'(busy), 1);
    rst = 1'b1;
    cyc(1);
    check("rs_busy", 32'(busy), 0);
    check("rs_sum", 32'(rif.sum), 0);
    check("rs_min", 32'(rif.min_cnt), 8);
    check("rs_max", 32'(rif.max_cnt), 0);
    check("rs_valid", 32'(rif.out_valid), 0);
    rst = 1'b0;
    cyc(8);
    check("rs_idle_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
